or_unit: RTL and testbench
==========================

Name: or_unit

Overview:
- Signed bitwise-OR datapath block for the 8-bit single-cycle processor ALU.
- Provides a combinational result C = A | B for the single-cycle path.
- Also provides a one-stage registered copy of the result, with a valid/ready handshake and status flags, for pipelined or multi-cycle consumers.

Parameters:
- WIDTH, 8, operand and result width in bits; minimum 1.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- A  input  WIDTH  signed operand A.
- B  input  WIDTH  signed operand B.
- C  output  WIDTH  combinational result, C = A | B.
- IN_VALID  input  1  A/B present a request for the registered path.
- IN_READY  output  1  the registered path can accept a request this cycle.
- OUT_VALID  output  1  RESULT holds an undelivered result.
- OUT_READY  input  1  the consumer accepts RESULT this cycle.
- RESULT  output  WIDTH  registered OR result.
- ZERO  output  1  RESULT == 0, registered together with RESULT.
- NEG  output  1  RESULT[WIDTH-1], registered together with RESULT.

Behaviour:
- Reset and clocking:
  - Clock is CLK; RESET is asynchronous and active-high.
  - While RESET is high: OUT_VALID=0, RESULT=0, ZERO=1, NEG=0.
  - C is unaffected by reset.
- Combinational path:
  - C = A | B bitwise, zero latency.
  - Values are two's complement; signedness does not alter the bit pattern.
  - No carry, overflow or saturation.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - Accept happens when IN_VALID && IN_READY at a rising CLK edge.
  - On accept: RESULT <= A|B, ZERO <= ((A|B)==0), NEG <= (A|B)[WIDTH-1], OUT_VALID <= 1.
  - Latency is 1 cycle.
  - Deliver happens when OUT_VALID && OUT_READY.
  - Deliver without a simultaneous accept: OUT_VALID <= 0; RESULT, ZERO and NEG hold.
- Simultaneous deliver and accept: the new result replaces the old one, OUT_VALID stays 1, giving full throughput of one result per cycle.
- Backpressure:
  - While OUT_VALID && !OUT_READY: RESULT, ZERO and NEG hold stable; IN_READY=0.
  - Inputs are ignored while IN_READY=0.
- IN_VALID asserted with IN_READY=0: no state change.
- RESET asserted mid-transaction: the pending result is discarded immediately and the block returns to reset values.

Optional Feature:
- Macro: OR_UNIT_ACCUM_EN.
- When defined:
  - Adds input port ACCUM (1 bit).
  - An accept with ACCUM=1 stores RESULT <= A | B | RESULT_prev; flags are computed on the stored value.
  - RESULT_prev is the current register value, whether or not it has been delivered.
  - An accept with ACCUM=0 behaves as the base design.
  - C is never affected by ACCUM.
- When undefined: no ACCUM port; behaviour is exactly the base design.

Decomposition:
- Shared package or_unit_pkg:
  - constant OR_UNIT_WIDTH_DEFAULT = 8;
  - typedef for the {RESULT, ZERO, NEG} result record.
- Natural sub-module or_unit_core: pure combinational OR plus flag computation, reused by both C and the register input.
- Top level holds the output register and the handshake.

Test Plan:
- Combinational: A=1,B=0 -> C=1; A=8'hD4(-44),B=10 -> C=8'hDE(-34); A=15,B=11 -> C=15.
- Registered: IN_VALID=1,A=8'hD4,B=10,OUT_READY=1 -> next cycle OUT_VALID=1, RESULT=8'hDE, NEG=1, ZERO=0.
- Zero flag: A=0,B=0 accepted -> RESULT=0, ZERO=1, NEG=0.
- Backpressure: a result is held with OUT_READY=0 for 3 cycles while new A/B are presented -> IN_READY=0, RESULT unchanged; OUT_READY=1 with IN_VALID=1 -> the new value is loaded on the next cycle.
- Async reset: RESET pulsed mid-cycle with OUT_VALID=1 -> OUT_VALID, RESULT and NEG drop to 0 and ZERO rises to 1 immediately, without waiting for a CLK edge.
- OR_UNIT_ACCUM_EN: accept A=8'h01 (ACCUM=0), then A=8'h10 (ACCUM=1), then A=8'h80 (ACCUM=1), with B=0 throughout -> RESULT=8'h01, 8'h11, 8'h91, with NEG=1 on the last.

Source files
------------

// File: rtl/or_unit_pkg.sv
// or_unit_pkg: shared constants and types for the or_unit datapath block.
//   OR_UNIT_WIDTH_DEFAULT : default operand/result width (8 bits).
//   or_unit_rec_t         : {result, zero, neg} record at the default width.
//   OR_UNIT_REC_RESET     : value the result record takes while reset is held.
//   or_unit_flags()       : builds a record from a raw OR value at the default width.
package or_unit_pkg;

  localparam int unsigned OR_UNIT_WIDTH_DEFAULT = 8;

  typedef struct packed {
    logic [OR_UNIT_WIDTH_DEFAULT-1:0] result;
    logic                             zero;
    logic                             neg;
  } or_unit_rec_t;

  localparam or_unit_rec_t OR_UNIT_REC_RESET = '{result: '0, zero: 1'b1, neg: 1'b0};

  function automatic or_unit_rec_t or_unit_flags(input logic [OR_UNIT_WIDTH_DEFAULT-1:0] v);
    or_unit_rec_t r;
    r.result = v;
    r.zero   = (v == '0);
    r.neg    = v[OR_UNIT_WIDTH_DEFAULT-1];
    return r;
  endfunction

endpackage

// File: rtl/or_unit_if.sv
// or_unit_if: operand, result and handshake bundle for or_unit.
//   A, B       : signed operands
//   C          : combinational A | B
//   IN_VALID / IN_READY   : request handshake into the result register
//   OUT_VALID / OUT_READY : delivery handshake out of the result register
//   RESULT, ZERO, NEG     : registered result and its flags
//   ACCUM      : present only when OR_UNIT_ACCUM_EN is defined; ORs the held
//                RESULT into the next accepted value.
// Modports: slave (the or_unit block), master (the producer/consumer side).
interface or_unit_if import or_unit_pkg::*; #(
  parameter int unsigned WIDTH = OR_UNIT_WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             IN_VALID;
  logic             IN_READY;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] RESULT;
  logic             ZERO;
  logic             NEG;
`ifdef OR_UNIT_ACCUM_EN
  logic             ACCUM;

  modport slave (
    input  A, B, IN_VALID, OUT_READY, ACCUM,
    output C, IN_READY, OUT_VALID, RESULT, ZERO, NEG
  );

  modport master (
    output A, B, IN_VALID, OUT_READY, ACCUM,
    input  C, IN_READY, OUT_VALID, RESULT, ZERO, NEG
  );
`else
  modport slave (
    input  A, B, IN_VALID, OUT_READY,
    output C, IN_READY, OUT_VALID, RESULT, ZERO, NEG
  );

  modport master (
    output A, B, IN_VALID, OUT_READY,
    input  C, IN_READY, OUT_VALID, RESULT, ZERO, NEG
  );
`endif

endinterface

// File: rtl/or_unit_core.sv
// or_unit_core: purely combinational bitwise OR with result flags.
//   a, b : operands (two's complement; signedness does not change the bits)
//   y    : a | b
//   zero : y == 0
//   neg  : sign bit of y
module or_unit_core import or_unit_pkg::*; #(
  parameter int unsigned WIDTH = OR_UNIT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             neg
);

  always_comb begin
    y    = a | b;
    zero = (y == '0);
    neg  = y[WIDTH-1];
  end

endmodule

// File: rtl/or_unit.sv
// or_unit: signed bitwise-OR block for the 8-bit ALU.
//   CLK   : rising-edge clock
//   RESET : asynchronous, active-high reset
//   bus   : or_unit_if.slave -- operands, combinational C, and a one-entry
//           registered result with valid/ready handshakes and ZERO/NEG flags.
// C is zero-latency and ignores reset. The result register accepts when
// IN_VALID && IN_READY, with IN_READY = !OUT_VALID || OUT_READY, so a deliver
// and an accept in the same cycle sustain one result per cycle.
// Optional feature macro: OR_UNIT_ACCUM_EN adds bus.ACCUM; an accept with
// ACCUM=1 stores A | B | RESULT (held value, delivered or not).
module or_unit import or_unit_pkg::*; #(
  parameter int unsigned WIDTH = OR_UNIT_WIDTH_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  or_unit_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
  } rec_t;

  localparam rec_t REC_RESET = '{result: '0, zero: 1'b1, neg: 1'b0};

  logic [WIDTH-1:0] ab_y;
  logic             ab_zero;
  logic             ab_neg;

  rec_t rec_q, rec_d, rec_in;
  logic out_valid_q, out_valid_d;
  logic in_ready;
  logic accept;
  logic deliver;

  or_unit_core #(.WIDTH(WIDTH)) u_core (
    .a    (bus.A),
    .b    (bus.B),
    .y    (ab_y),
    .zero (ab_zero),
    .neg  (ab_neg)
  );

  assign bus.C = ab_y;

`ifdef OR_UNIT_ACCUM_EN
  logic [WIDTH-1:0] acc_sel;

  assign acc_sel = bus.ACCUM ? rec_q.result : '0;

  // Flags are merged from the shared core's A|B flags rather than recomputed:
  // an OR is zero only if both parts are zero, and negative if either sign is set.
  always_comb begin
    rec_in        = REC_RESET;
    rec_in.result = ab_y | acc_sel;
    rec_in.zero   = ab_zero & ~(|acc_sel);
    rec_in.neg    = ab_neg | acc_sel[WIDTH-1];
  end
`else
  always_comb begin
    rec_in        = REC_RESET;
    rec_in.result = ab_y;
    rec_in.zero   = ab_zero;
    rec_in.neg    = ab_neg;
  end
`endif

  assign in_ready = !out_valid_q || bus.OUT_READY;
  assign accept   = bus.IN_VALID && in_ready;
  assign deliver  = out_valid_q && bus.OUT_READY;

  always_comb begin
    rec_d       = rec_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      rec_d       = rec_in;
      out_valid_d = 1'b1;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rec_q       <= REC_RESET;
      out_valid_q <= 1'b0;
    end else begin
      rec_q       <= rec_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.RESULT    = rec_q.result;
  assign bus.ZERO      = rec_q.zero;
  assign bus.NEG       = rec_q.neg;

endmodule

// File: tb/tb_or_unit.sv
// tb_or_unit: directed self-checking bench for or_unit (WIDTH = 8).
// Define OR_UNIT_ACCUM_EN for both bench and RTL to exercise the ACCUM feature.
module tb_or_unit;
  import or_unit_pkg::*;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int unsigned passed;
  int unsigned total;

  or_unit_if #(.WIDTH(W)) bus ();

  or_unit #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst          = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b0;
`ifdef OR_UNIT_ACCUM_EN
    bus.ACCUM    = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;

    // Reset values, and C live during reset
    check("rst_out_valid", {7'b0, bus.OUT_VALID}, 8'h00);
    check("rst_result",    bus.RESULT,            8'h00);
    check("rst_zero",      {7'b0, bus.ZERO},      8'h01);
    check("rst_neg",       {7'b0, bus.NEG},       8'h00);
    check("rst_in_ready",  {7'b0, bus.IN_READY},  8'h01);
    bus.A = 8'h55; bus.B = 8'hAA; #1;
    check("c_during_rst",  bus.C,                 8'hFF);

    tick();
    tick();
    rst = 1'b0;

    // Combinational path
    bus.A = 8'h01; bus.B = 8'h00; #1;
    check("c_1_0", bus.C, 8'h01);
    bus.A = 8'hD4; bus.B = 8'h0A; #1;
    check("c_neg44_10", bus.C, 8'hDE);
    bus.A = 8'h0F; bus.B = 8'h0B; #1;
    check("c_15_11", bus.C, 8'h0F);

    // Registered path, 1-cycle latency
    bus.A = 8'hD4; bus.B = 8'h0A; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
    tick();
    check("reg_out_valid", {7'b0, bus.OUT_VALID}, 8'h01);
    check("reg_result",    bus.RESULT,            8'hDE);
    check("reg_neg",       {7'b0, bus.NEG},       8'h01);
    check("reg_zero",      {7'b0, bus.ZERO},      8'h00);

    // Zero result
    bus.A = 8'h00; bus.B = 8'h00;
    tick();
    check("zero_result", bus.RESULT,            8'h00);
    check("zero_zero",   {7'b0, bus.ZERO},      8'h01);
    check("zero_neg",    {7'b0, bus.NEG},       8'h00);
    check("zero_valid",  {7'b0, bus.OUT_VALID}, 8'h01);

    // Deliver without accept: valid drops, value holds
    bus.IN_VALID = 1'b0; bus.A = 8'h77;
    tick();
    check("drain_valid",  {7'b0, bus.OUT_VALID}, 8'h00);
    check("drain_result", bus.RESULT,            8'h00);
    check("drain_zero",   {7'b0, bus.ZERO},      8'h01);

    // Backpressure
    bus.A = 8'h3C; bus.B = 8'h41; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b0;
    tick();
    check("bp_load", bus.RESULT, 8'h7D);
    bus.A = 8'h80; bus.B = 8'h01; #1;
    check("bp_in_ready", {7'b0, bus.IN_READY}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_result", bus.RESULT,            8'h7D);
      check("bp_hold_valid",  {7'b0, bus.OUT_VALID}, 8'h01);
      check("bp_hold_neg",    {7'b0, bus.NEG},       8'h00);
    end
    bus.OUT_READY = 1'b1; #1;
    check("bp_release_ready", {7'b0, bus.IN_READY}, 8'h01);
    tick();
    check("bp_new_result", bus.RESULT,            8'h81);
    check("bp_new_neg",    {7'b0, bus.NEG},       8'h01);
    check("bp_new_valid",  {7'b0, bus.OUT_VALID}, 8'h01);

    // Back-to-back throughput
    bus.A = 8'h02; bus.B = 8'h04;
    tick();
    check("stream0", bus.RESULT, 8'h06);
    bus.A = 8'hFF; bus.B = 8'h00;
    tick();
    check("stream1", bus.RESULT, 8'hFF);

    // Hold with no request, then async reset mid-cycle
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
    tick();
    check("pre_rst_valid", {7'b0, bus.OUT_VALID}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("arst_valid",  {7'b0, bus.OUT_VALID}, 8'h00);
    check("arst_result", bus.RESULT,            8'h00);
    check("arst_zero",   {7'b0, bus.ZERO},      8'h01);
    check("arst_neg",    {7'b0, bus.NEG},       8'h00);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", {7'b0, bus.OUT_VALID}, 8'h00);

`ifdef OR_UNIT_ACCUM_EN
    bus.B = 8'h00; bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1;
    bus.A = 8'h01; bus.ACCUM = 1'b0;
    tick();
    check("acc0", bus.RESULT, 8'h01);
    bus.A = 8'h10; bus.ACCUM = 1'b1;
    tick();
    check("acc1", bus.RESULT, 8'h11);
    bus.A = 8'h80; #1;
    check("acc_c_unaffected", bus.C, 8'h80);
    tick();
    check("acc2",     bus.RESULT,       8'h91);
    check("acc2_neg", {7'b0, bus.NEG},  8'h01);
    check("acc2_zero", {7'b0, bus.ZERO}, 8'h00);
    bus.IN_VALID = 1'b0; bus.ACCUM = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
